// File: rtl/alu_shift_seq.sv
// Variable-distance shift sequencer: splits a 0..31 bit shift into 16/4/1 bit ALU ops,
// one per clock, and returns the final value and ALU flags through a start/busy/done handshake.
module alu_shift_seq #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] OP_ADD  = 4'd0,
  parameter logic [3:0] OP_SHL  = 4'd8,
  parameter logic [3:0] OP_SHR  = 4'd9,
  parameter logic [3:0] OP_SL4  = 4'd12,
  parameter logic [3:0] OP_SL16 = 4'd13,
  parameter logic [3:0] OP_SR4  = 4'd14,
  parameter logic [3:0] OP_SR16 = 4'd15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [4:0]       amount,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             z_out,
  output logic             n_out,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_n
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [4:0]       rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic [4:0]       step;

  // Largest fixed-distance op that still fits the remaining distance.
  always_comb begin
    alu_op = OP_ADD;
    step   = 5'd0;
    if (state_q == RUN) begin
      if (rem_q >= 5'd16) begin
        alu_op = dir_q ? OP_SR16 : OP_SL16;
        step   = 5'd16;
      end else if (rem_q >= 5'd4) begin
        alu_op = dir_q ? OP_SR4 : OP_SL4;
        step   = 5'd4;
      end else if (rem_q >= 5'd1) begin
        alu_op = dir_q ? OP_SHR : OP_SHL;
        step   = 5'd1;
      end
    end
  end

  assign alu_a   = val_q;
  assign alu_b   = '0;
  assign alu_cin = 1'b0;

  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    c_d      = c_q;
    z_d      = z_q;
    n_d      = n_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          val_d   = value;
          rem_d   = amount;
          dir_d   = dir;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        val_d = alu_result;
        rem_d = rem_q - step;
        // rem_q == step also covers the zero-distance ADD (rem 0, step 0).
        if (rem_q == step) begin
          result_d = alu_result;
          c_d      = alu_c;
          z_d      = alu_z;
          n_d      = alu_n;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      val_q    <= '0;
      rem_q    <= '0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      val_q    <= val_d;
      rem_q    <= rem_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_q;
  assign z_out  = z_q;
  assign n_out  = n_q;

endmodule
